useq_ctrl: RTL and testbench



---
 rtl/useq_ctrl.sv | 127 ++++++++++++
 tb/tb_useq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/useq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : useq_ctrl
// Brief  : Microcode sequencer holding IR and uPC, driving datapath control
//          from an external microcode store with stall, flags, halt and trap.
// Rev    : 1.0  initial release
// ============================================================================
module useq_ctrl #(
    parameter int N      = 16,
    parameter int UPC_W  = 3,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         din,
    input  logic                mem_ready,
    input  logic                o_flag,
    input  logic                z_flag,
    input  logic                n_flag,
    output logic [UPC_W+4:0]    uaddr,
    input  logic [CTRL_W+7:0]   uword,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                ctrl_valid,
    output logic [2:0]          waddr,
    output logic [2:0]          ra,
    output logic [2:0]          rb,
    output logic [N-1:0]        offset,
    output logic                halted,
    output logic                ucode_err,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [UPC_W-1:0] c_UPC_MAX = '1;

    logic [15:0]        r_ir;
    logic [UPC_W-1:0]   r_upc;
    logic               r_flag;
    logic               r_halted;
    logic               r_ucode_err;
    logic [CNT_W-1:0]   r_retired;

    logic               w_last;
    logic               w_ir_ld;
    logic               w_mem_wait;
    logic               w_halt;
    logic [1:0]         w_flag_sel;
    logic               w_flag_cap;
    logic               w_unused_rsvd;
    logic               w_stall;
    logic               w_adv;
    logic               w_flag_val;
    logic [N-1:0]       w_off_long;
    logic [N-1:0]       w_off_short;

    assign w_last        = uword[7];
    assign w_ir_ld       = uword[6];
    assign w_mem_wait    = uword[5];
    assign w_halt        = uword[4];
    assign w_flag_sel    = uword[3:2];
    assign w_flag_cap    = uword[1];
    assign w_unused_rsvd = uword[0];

    assign w_stall    = w_mem_wait & ~mem_ready;
    assign w_adv      = ~r_halted & ~w_stall;

    always_comb begin
        w_flag_val = 1'b0;
        case (w_flag_sel)
            2'b00:   w_flag_val = o_flag;
            2'b01:   w_flag_val = z_flag;
            2'b10:   w_flag_val = n_flag;
            default: w_flag_val = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir        <= '0;
            r_upc       <= '0;
            r_flag      <= 1'b0;
            r_halted    <= 1'b0;
            r_ucode_err <= 1'b0;
            r_retired   <= '0;
        end else if (w_adv) begin
            // last beats the overrun trap when both land on the final slot
            if (w_last) begin
                r_upc <= '0;
            end else if (r_upc == c_UPC_MAX) begin
                r_upc       <= '0;
                r_ucode_err <= 1'b1;
            end else begin
                r_upc <= r_upc + UPC_W'(1);
            end

            if (w_ir_ld)
                r_ir <= din;

            if (w_flag_cap)
                r_flag <= w_flag_val;
            else if (w_last)
                r_flag <= 1'b0;

            if (w_last)
                r_retired <= r_retired + CNT_W'(1);

            if (w_halt)
                r_halted <= 1'b1;
        end
    end

    assign w_off_long  = N'($signed(r_ir[11:0]));
    assign w_off_short = N'($signed(r_ir[8:0]));

    assign uaddr      = {r_ir[15:12], r_flag, r_upc};
    assign ctrl       = r_halted ? '0 : uword[CTRL_W+7:8];
    assign ctrl_valid = w_adv;
    assign waddr      = r_ir[11:9];
    assign ra         = r_ir[8:6];
    assign rb         = r_ir[5:3];
    assign offset     = (r_ir[15:14] == 2'b11) ? w_off_long : w_off_short;
    assign halted     = r_halted;
    assign ucode_err  = r_ucode_err;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_useq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_useq_ctrl
// Brief  : Directed scoreboard bench for useq_ctrl with a modelled microcode ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_useq_ctrl;

    localparam logic [7:0] c_PARK = 8'hA0;   // last | mem_wait: idles in stall
    localparam logic [7:0] c_LAST = 8'h80;
    localparam logic [7:0] c_IRLD = 8'h40;
    localparam logic [7:0] c_MW   = 8'h20;
    localparam logic [7:0] c_HALT = 8'h10;
    localparam logic [7:0] c_S01  = 8'h04;
    localparam logic [7:0] c_S10  = 8'h08;
    localparam logic [7:0] c_FCAP = 8'h02;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        mem_ready = 1'b0;
    logic        o_flag = 1'b0, z_flag = 1'b0, n_flag = 1'b0;
    logic [7:0]  uaddr;
    logic [23:0] uword;
    logic [15:0] ctrl;
    logic        ctrl_valid;
    logic [2:0]  waddr, ra, rb;
    logic [15:0] offset;
    logic        halted, ucode_err;
    logic [3:0]  retired;

    logic [23:0] rom [256];
    logic [7:0]  exp_q [$];
    int          n_vec = 0;
    int          n_miss = 0;

    useq_ctrl #(.N(16), .UPC_W(3), .CTRL_W(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .mem_ready(mem_ready),
        .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag),
        .uaddr(uaddr), .uword(uword), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
        .waddr(waddr), .ra(ra), .rb(rb), .offset(offset),
        .halted(halted), .ucode_err(ucode_err), .retired(retired)
    );

    always #5 clk = ~clk;

    assign uword = rom[uaddr];

    function automatic logic [23:0] mk(input logic [7:0] a, input logic [7:0] seq);
        return {16'h5A00 | {8'h00, a}, seq};
    endfunction

    // Monitor: every committed microword must match the next scoreboard entry
    always @(negedge clk) begin
        if (!rst && ctrl_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL commit_unexpected: got uaddr=%h ctrl=%h, expected no commit", uaddr, ctrl);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (uaddr !== e || ctrl !== (16'h5A00 | {8'h00, e})) begin
                    n_miss++;
                    $display("FAIL commit: got uaddr=%h ctrl=%h, expected uaddr=%h ctrl=%h",
                             uaddr, ctrl, e, 16'h5A00 | {8'h00, e});
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = mk(8'(a), c_PARK);
        do_reset();

        // Reset state
        chk("rst_uaddr", uaddr, 8'h00);
        chk("rst_regs", {waddr, ra, rb}, 9'h000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", ucode_err, 1'b0);
        chk("rst_retired", retired, 4'h0);
        chk("rst_offset", offset, 16'h0000);

        // 1: load IR at upc 0, end at upc 2
        din = 16'h1A5F;
        rom[8'h00] = mk(8'h00, c_IRLD);
        rom[8'h11] = mk(8'h11, 8'h00);
        rom[8'h12] = mk(8'h12, c_LAST);
        exp_q.push_back(8'h00); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        step(); rom[8'h00] = mk(8'h00, c_PARK);
        chk("t1_uaddr1", uaddr, 8'h11);
        step(); chk("t1_uaddr2", uaddr, 8'h12);
        step();
        chk("t1_uaddr_end", uaddr, 8'h10);
        chk("t1_fields", {waddr, ra, rb}, {3'd5, 3'd1, 3'd3});
        chk("t1_offset", offset, 16'h005F);
        chk("t1_retired", retired, 4'h1);

        // 2: memory-wait stall at upc 1 for three cycles
        rom[8'h10] = mk(8'h10, 8'h00);
        rom[8'h11] = mk(8'h11, c_MW);
        rom[8'h12] = mk(8'h12, c_LAST);
        exp_q.push_back(8'h10);
        step(); rom[8'h10] = mk(8'h10, c_PARK);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_uaddr", uaddr, 8'h11);
            chk("t2_stall_valid", ctrl_valid, 1'b0);
            chk("t2_stall_retired", retired, 4'h1);
            step();
        end
        mem_ready = 1'b1;
        exp_q.push_back(8'h11);
        step(); mem_ready = 1'b0;
        chk("t2_release_uaddr", uaddr, 8'h12);
        exp_q.push_back(8'h12);
        step();
        chk("t2_end_uaddr", uaddr, 8'h10);
        chk("t2_retired", retired, 4'h2);

        // 3: capture z at upc 1, then last with a simultaneous n capture
        z_flag = 1'b1; n_flag = 1'b1;
        rom[8'h10] = mk(8'h10, 8'h00);
        rom[8'h11] = mk(8'h11, c_FCAP | c_S01);
        rom[8'h1A] = mk(8'h1A, c_LAST | c_FCAP | c_S10);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h1A);
        step(); rom[8'h10] = mk(8'h10, c_PARK);
        chk("t3_uaddr1", uaddr, 8'h11);
        step(); z_flag = 1'b0;
        chk("t3_flag_uaddr", uaddr, 8'h1A);
        step(); n_flag = 1'b0;
        chk("t3_last_cap_uaddr", uaddr, 8'h18);
        chk("t3_retired", retired, 4'h3);

        // 4: runaway microprogram overruns the uPC
        for (int a = 8'h18; a <= 8'h1F; a++) begin
            rom[a] = mk(8'(a), 8'h00);
            exp_q.push_back(8'(a));
        end
        step(); rom[8'h18] = mk(8'h18, c_PARK);
        repeat (6) step();
        chk("t4_err_before", ucode_err, 1'b0);
        step();
        chk("t4_err_after", ucode_err, 1'b1);
        chk("t4_wrap_uaddr", uaddr, 8'h18);
        repeat (2) step();
        chk("t4_err_sticky", ucode_err, 1'b1);
        chk("t4_retired", retired, 4'h3);
        do_reset();
        chk("t4_err_cleared", ucode_err, 1'b0);
        chk("t4_rst_retired", retired, 4'h0);

        // 5: halt with last; frozen until reset even with mem_ready high
        rom[8'h00] = mk(8'h00, 8'h00);
        rom[8'h01] = mk(8'h01, c_HALT | c_LAST);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        step(); rom[8'h00] = mk(8'h00, c_PARK);
        chk("t5_uaddr1", uaddr, 8'h01);
        step();
        chk("t5_halted", halted, 1'b1);
        chk("t5_retired", retired, 4'h1);
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t5_frozen", {uaddr, ctrl, 3'b000, ctrl_valid, retired}, {8'h00, 16'h0000, 4'h0, 4'h1});
            step();
        end
        mem_ready = 1'b0;
        do_reset();
        chk("t5_rst_halted", halted, 1'b0);
        chk("t5_rst_uaddr", uaddr, 8'h00);

        // 6: long-form offset, then retired counter wrap
        din = 16'hC801;
        rom[8'h00] = mk(8'h00, c_IRLD | c_LAST);
        exp_q.push_back(8'h00);
        step(); rom[8'h00] = mk(8'h00, c_PARK);
        chk("t6_uaddr", uaddr, 8'hC0);
        chk("t6_offset", offset, 16'hF801);
        chk("t6_waddr", waddr, 3'd4);
        chk("t6_retired", retired, 4'h1);
        rom[8'hC0] = mk(8'hC0, c_LAST);
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(8'hC0);
            step();
            if (i == 13) chk("t6_retired_max", retired, 4'hF);
        end
        rom[8'hC0] = mk(8'hC0, c_PARK);
        chk("t6_retired_wrap", retired, 4'h0);
        repeat (2) step();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
